sdr_cmd_monitor: RTL and testbench

Passive, parametrised SDRAM command-bus monitor for the sdr_ctrl verification environment. It probes the controller's SDRAM command pins through the whitebox path, decodes each cycle's command, tracks per-bank open/closed state with tRCD/tRP timers, keeps saturating per-command counters, and flags protocol violations. It drives nothing back into the DUV and sits beside the whitebox interface in the bench top.

---
 rtl/sdr_mon_pkg.sv | 48 ++++
 rtl/sdr_cmd_monitor_if.sv | 25 ++
 rtl/sdr_bank_tracker.sv | 79 +++++++
 rtl/sdr_cmd_monitor.sv | 182 ++++++++++++++++++
 tb/tb_sdr_cmd_monitor.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdr_mon_pkg.sv
// sdr_cmd_monitor shared types: command, bank state and error enums.
// Also holds the pin-to-command decode function.
package sdr_mon_pkg;

  typedef enum logic [3:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE,
    CMD_PREA, CMD_REF, CMD_MRS, CMD_BST
  } sdr_cmd_e;

  typedef enum logic [1:0] {
    IDLE, ACTIVATING, ACTIVE, PRECHARGING
  } bank_state_e;

  typedef enum logic [3:0] {
    ERR_NONE      = 4'd0,
    ERR_RW_CLOSED = 4'd1,
    ERR_TRCD      = 4'd2,
    ERR_ACT_OPEN  = 4'd3,
    ERR_TRP       = 4'd4,
    ERR_REF_OPEN  = 4'd5,
    ERR_MRS_OPEN  = 4'd6
  } err_code_e;

  function automatic sdr_cmd_e sdr_decode(
    input logic cs_n,
    input logic ras_n,
    input logic cas_n,
    input logic we_n,
    input logic a10
  );
    sdr_cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACT;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
        3'b001:  c = CMD_REF;
        3'b000:  c = CMD_MRS;
        3'b110:  c = CMD_BST;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/sdr_cmd_monitor_if.sv
// SDRAM command-pin probe bundle seen by sdr_cmd_monitor.
interface sdr_cmd_monitor_if #(
  parameter int BA_W   = 2,
  parameter int ADDR_W = 13
);
  logic              sdr_cs_n;
  logic              sdr_ras_n;
  logic              sdr_cas_n;
  logic              sdr_we_n;
  logic [BA_W-1:0]   sdr_ba;
  logic [ADDR_W-1:0] sdr_addr;
  logic              sdr_init_done;

  modport master (
    output sdr_cs_n, sdr_ras_n, sdr_cas_n,
    output sdr_we_n, sdr_ba, sdr_addr,
    output sdr_init_done
  );

  modport slave (
    input sdr_cs_n, sdr_ras_n, sdr_cas_n,
    input sdr_we_n, sdr_ba, sdr_addr,
    input sdr_init_done
  );
endinterface

// File: rtl/sdr_bank_tracker.sv
// One SDRAM bank's state and tRCD/tRP timer (timer only with
// SDR_MON_TIMING_EN); raises per-bank violation requests.
module sdr_bank_tracker
  import sdr_mon_pkg::*;
#(
  parameter int TRCD = 3,
  parameter int TRP  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act,
  input  logic        pre,
  input  logic        rw,
  output bank_state_e state,
  output logic        rw_closed,
  output logic        trcd_err,
  output logic        act_open,
  output logic        trp_err
);

  bank_state_e state_q, state_d;

  assign state    = state_q;
  assign act_open = act &&
    (state_q == ACTIVATING || state_q == ACTIVE);

`ifdef SDR_MON_TIMING_EN
  logic [3:0] tmr_q, tmr_d;

  // Leave a wait state on the edge the timer hits zero.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (act) begin
      state_d = (TRCD == 1) ? ACTIVE : ACTIVATING;
      tmr_d   = 4'(TRCD - 1);
    end else if (pre && (state_q == ACTIVATING ||
                         state_q == ACTIVE)) begin
      state_d = (TRP == 1) ? IDLE : PRECHARGING;
      tmr_d   = 4'(TRP - 1);
    end else if (state_q == ACTIVATING) begin
      tmr_d = tmr_q - 4'd1;
      if (tmr_q == 4'd1) state_d = ACTIVE;
    end else if (state_q == PRECHARGING) begin
      tmr_d = tmr_q - 4'd1;
      if (tmr_q == 4'd1) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end

  assign rw_closed = rw &&
    (state_q == IDLE || state_q == PRECHARGING);
  assign trcd_err  = rw && state_q == ACTIVATING;
  assign trp_err   = act && state_q == PRECHARGING;
`else
  logic unused_prm;
  assign unused_prm = ^{4'(TRCD), 4'(TRP)};

  always_comb begin
    state_d = state_q;
    if (act)      state_d = ACTIVE;
    else if (pre) state_d = IDLE;
  end

  assign rw_closed = rw && state_q != ACTIVE;
  assign trcd_err  = 1'b0;
  assign trp_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/sdr_cmd_monitor.sv
// Passive SDRAM command-bus monitor: decode, bank tracking, counters,
// violation flags. Timing checks built with SDR_MON_TIMING_EN.
module sdr_cmd_monitor
  import sdr_mon_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = $clog2(NUM_BANKS),
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 32,
  parameter int TRCD      = 3,
  parameter int TRP       = 3
) (
  input  logic                 sdram_clk,
  input  logic                 wb_rst_i,
  sdr_cmd_monitor_if.slave     bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_act,
  output logic [CNT_W-1:0]     cnt_rd,
  output logic [CNT_W-1:0]     cnt_wr,
  output logic [CNT_W-1:0]     cnt_pre,
  output logic [CNT_W-1:0]     cnt_ref,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 err_valid,
  output logic [3:0]           err_code,
  output logic [BA_W-1:0]      err_bank,
  output logic                 err_sticky
);

  sdr_cmd_e    cmd;
  bank_state_e st [NUM_BANKS];
  logic [NUM_BANKS-1:0] hit_act, hit_pre, hit_rw;
  logic [NUM_BANKS-1:0] rwc, trcd, aopen, trp;
  logic        busy, err_hit;
  logic [BA_W-1:0] busy_bank, sel_bank;
  err_code_e   sel_code;
  logic        unused_ok;

  assign unused_ok = ^bus.sdr_addr;
  assign cmd = sdr_decode(bus.sdr_cs_n, bus.sdr_ras_n,
                          bus.sdr_cas_n, bus.sdr_we_n,
                          bus.sdr_addr[10]);

  always_comb begin
    hit_act = '0;
    hit_pre = '0;
    hit_rw  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bus.sdr_ba == BA_W'(b)) begin
        hit_act[b] = cmd == CMD_ACT;
        hit_pre[b] = cmd == CMD_PRE;
        hit_rw[b]  = cmd == CMD_RD || cmd == CMD_WR;
      end
      if (cmd == CMD_PREA) hit_pre[b] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sdr_bank_tracker #(.TRCD(TRCD), .TRP(TRP)) u_bank (
      .clk       (sdram_clk),
      .rst       (wb_rst_i),
      .act       (hit_act[g]),
      .pre       (hit_pre[g]),
      .rw        (hit_rw[g]),
      .state     (st[g]),
      .rw_closed (rwc[g]),
      .trcd_err  (trcd[g]),
      .act_open  (aopen[g]),
      .trp_err   (trp[g])
    );
    assign bank_open[g] = st[g] == ACTIVE;
  end

  // Downward scan leaves the lowest non-idle bank.
  always_comb begin
    busy      = 1'b0;
    busy_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (st[b] != IDLE) begin
        busy      = 1'b1;
        busy_bank = BA_W'(b);
      end
    end
  end

  always_comb begin
    err_hit  = 1'b1;
    sel_code = ERR_NONE;
    sel_bank = bus.sdr_ba;
    priority case (1'b1)
      |rwc:   sel_code = ERR_RW_CLOSED;
      |trcd:  sel_code = ERR_TRCD;
      |aopen: sel_code = ERR_ACT_OPEN;
      |trp:   sel_code = ERR_TRP;
      (cmd == CMD_REF && busy): begin
        sel_code = ERR_REF_OPEN;
        sel_bank = busy_bank;
      end
      (cmd == CMD_MRS && busy): begin
        sel_code = ERR_MRS_OPEN;
        sel_bank = busy_bank;
      end
      default: err_hit = 1'b0;
    endcase
  end

  logic            err_valid_q, err_valid_d;
  logic [3:0]      err_code_q, err_code_d;
  logic [BA_W-1:0] err_bank_q, err_bank_d;
  logic            err_sticky_q, err_sticky_d;

  always_comb begin
    err_valid_d  = err_hit && bus.sdr_init_done;
    err_code_d   = err_code_q;
    err_bank_d   = err_bank_q;
    err_sticky_d = err_sticky_q | err_valid_d;
    if (err_valid_d) begin
      err_code_d = sel_code;
      err_bank_d = sel_bank;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  logic [CNT_W-1:0] act_q, rd_q, wr_q, pre_q, ref_q;
  logic [CNT_W-1:0] act_d, rd_d, wr_d, pre_d, ref_d;

  always_comb begin
    act_d = sat_inc(act_q, cmd == CMD_ACT);
    rd_d  = sat_inc(rd_q,  cmd == CMD_RD);
    wr_d  = sat_inc(wr_q,  cmd == CMD_WR);
    pre_d = sat_inc(pre_q,
              cmd == CMD_PRE || cmd == CMD_PREA);
    ref_d = sat_inc(ref_q, cmd == CMD_REF);
    if (cnt_clr) begin
      act_d = '0;
      rd_d  = '0;
      wr_d  = '0;
      pre_d = '0;
      ref_d = '0;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (wb_rst_i) begin
      act_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      pre_q        <= '0;
      ref_q        <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_bank_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      act_q        <= act_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      pre_q        <= pre_d;
      ref_q        <= ref_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_bank_q   <= err_bank_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign cnt_act    = act_q;
  assign cnt_rd     = rd_q;
  assign cnt_wr     = wr_q;
  assign cnt_pre    = pre_q;
  assign cnt_ref    = ref_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_bank   = err_bank_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Directed bench for sdr_cmd_monitor (4 banks, 4-bit counters).
// Follows the SDR_MON_TIMING_EN setting of the build.
module tb_sdr_cmd_monitor;

  localparam logic [2:0] OP_ACT = 3'b011;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_REF = 3'b001;
  localparam logic [2:0] OP_MRS = 3'b000;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;
  logic [3:0] cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref;
  logic [3:0] bank_open;
  logic       err_valid;
  logic [3:0] err_code;
  logic [1:0] err_bank;
  logic       err_sticky;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdr_cmd_monitor_if #(.BA_W(2), .ADDR_W(13)) bus ();

  sdr_cmd_monitor #(
    .NUM_BANKS(4), .BA_W(2), .ADDR_W(13),
    .CNT_W(4), .TRCD(3), .TRP(3)
  ) dut (
    .sdram_clk  (clk),
    .wb_rst_i   (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .cnt_act    (cnt_act),
    .cnt_rd     (cnt_rd),
    .cnt_wr     (cnt_wr),
    .cnt_pre    (cnt_pre),
    .cnt_ref    (cnt_ref),
    .bank_open  (bank_open),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .err_bank   (err_bank),
    .err_sticky (err_sticky)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op,
                       input int ba,
                       input logic a10);
    bus.sdr_cs_n  = 1'b0;
    {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = op;
    bus.sdr_ba    = 2'(ba);
    bus.sdr_addr  = '0;
    bus.sdr_addr[10] = a10;
    @(posedge clk);
    #1;
    bus.sdr_cs_n  = 1'b1;
  endtask

  task automatic nop();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) nop();
  endtask

  task automatic chk_err(input string tag,
                         input logic v,
                         input logic [3:0] c,
                         input logic [1:0] b);
    chk({tag, "_valid"}, 32'(err_valid), 32'(v));
    chk({tag, "_code"},  32'(err_code),  32'(c));
    chk({tag, "_bank"},  32'(err_bank),  32'(b));
  endtask

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.sdr_cs_n = 1'b1;
    bus.sdr_ras_n = 1'b1;
    bus.sdr_cas_n = 1'b1;
    bus.sdr_we_n = 1'b1;
    bus.sdr_ba = '0;
    bus.sdr_addr = '0;
    bus.sdr_init_done = 1'b1;
    repeat (2) nop();

    chk("rst_cnt_act", 32'(cnt_act), 0);
    chk("rst_cnt_pre", 32'(cnt_pre), 0);
    chk("rst_open", 32'(bank_open), 0);
    chk_err("rst", 1'b0, 4'd0, 2'd0);
    chk("rst_sticky", 32'(err_sticky), 0);
    rst = 1'b0;
    nop();

`ifdef SDR_MON_TIMING_EN
    drive(OP_ACT, 0, 1'b0);
    chk("trcd_open_early", 32'(bank_open), 0);
    nop();
    nop();
    chk("trcd_open_late", 32'(bank_open), 1);
    drive(OP_RD, 0, 1'b0);
    chk("trcd_rd_ok", 32'(err_valid), 0);
    chk("trcd_cnt_rd", 32'(cnt_rd), 1);
    chk("trcd_sticky0", 32'(err_sticky), 0);
    drive(OP_ACT, 1, 1'b0);
    nop();
    drive(OP_WR, 1, 1'b0);
    chk_err("trcd_wr", 1'b1, 4'd2, 2'd1);
    chk("trcd_sticky", 32'(err_sticky), 1);
    nop();
    chk("trcd_pulse", 32'(err_valid), 0);
    settle();
    drive(OP_PRE, 1, 1'b0);
    drive(OP_ACT, 1, 1'b0);
    chk_err("trp_act", 1'b1, 4'd4, 2'd1);
    settle();
    drive(OP_PRE, 1, 1'b0);
    settle();
    chk("trp_open", 32'(bank_open), 1);
`else
    drive(OP_ACT, 0, 1'b0);
    chk("act_open_now", 32'(bank_open), 1);
    chk("act_cnt", 32'(cnt_act), 1);
    drive(OP_RD, 0, 1'b0);
    chk("rd_no_err", 32'(err_valid), 0);
    chk("rd_cnt", 32'(cnt_rd), 1);
    chk("rd_sticky0", 32'(err_sticky), 0);
`endif

    cnt_clr = 1'b1;
    nop();
    cnt_clr = 1'b0;
    chk("clr_act", 32'(cnt_act), 0);
    chk("clr_rd", 32'(cnt_rd), 0);
    chk("clr_wr", 32'(cnt_wr), 0);
    chk("clr_pre", 32'(cnt_pre), 0);
    chk("clr_ref", 32'(cnt_ref), 0);

    drive(OP_WR, 1, 1'b0);
    chk_err("wr_closed", 1'b1, 4'd1, 2'd1);
    chk("wr_sticky", 32'(err_sticky), 1);
    chk("wr_cnt", 32'(cnt_wr), 1);
    nop();
    chk_err("wr_hold", 1'b0, 4'd1, 2'd1);

    drive(OP_ACT, 2, 1'b0);
    settle();
    chk("open_b0b2", 32'(bank_open), 4'b0101);
    drive(OP_ACT, 0, 1'b0);
    chk_err("act_open", 1'b1, 4'd3, 2'd0);
    chk("act_open_cnt", 32'(cnt_act), 2);
    settle();
    chk("reopen_b0", 32'(bank_open), 4'b0101);

    drive(OP_REF, 0, 1'b0);
    chk_err("ref_open", 1'b1, 4'd5, 2'd0);
    chk("ref_cnt1", 32'(cnt_ref), 1);
    drive(OP_MRS, 3, 1'b0);
    chk_err("mrs_open", 1'b1, 4'd6, 2'd0);
    chk("mrs_nocnt", 32'(cnt_ref), 1);

    drive(OP_PRE, 3, 1'b1);
    chk("prea_valid", 32'(err_valid), 0);
    chk("prea_cnt", 32'(cnt_pre), 1);
    settle();
    chk("prea_open", 32'(bank_open), 0);
    drive(OP_REF, 0, 1'b0);
    chk("ref_ok", 32'(err_valid), 0);
    chk("ref_cnt2", 32'(cnt_ref), 2);
    drive(OP_PRE, 1, 1'b0);
    chk("pre_idle_ok", 32'(err_valid), 0);
    chk("pre_idle_cnt", 32'(cnt_pre), 2);

    bus.sdr_init_done = 1'b0;
    drive(OP_ACT, 3, 1'b0);
    settle();
    chk("ni_open", 32'(bank_open), 4'b1000);
    drive(OP_REF, 0, 1'b0);
    chk_err("ni_ref", 1'b0, 4'd6, 2'd0);
    chk("ni_cnt_ref", 32'(cnt_ref), 3);
    chk("ni_cnt_act", 32'(cnt_act), 3);
    drive(OP_RD, 2, 1'b0);
    chk("ni_rd", 32'(err_valid), 0);
    chk("ni_cnt_rd", 32'(cnt_rd), 1);
    drive(OP_PRE, 3, 1'b0);
    settle();
    bus.sdr_init_done = 1'b1;

    cnt_clr = 1'b1;
    nop();
    cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(OP_ACT, 3, 1'b0);
      settle();
      drive(OP_PRE, 3, 1'b0);
      settle();
    end
    chk("sat_act", 32'(cnt_act), 15);
    chk("sat_pre", 32'(cnt_pre), 15);
    chk("sat_ref", 32'(cnt_ref), 0);
    chk("sat_noerr", 32'(err_valid), 0);

    cnt_clr = 1'b1;
    drive(OP_ACT, 3, 1'b0);
    cnt_clr = 1'b0;
    chk("clr_act_cmd", 32'(cnt_act), 0);
    chk("clr_pre_cmd", 32'(cnt_pre), 0);
`ifndef SDR_MON_TIMING_EN
    chk("clr_open_now", 32'(bank_open), 4'b1000);
`endif
    settle();
    chk("clr_open", 32'(bank_open), 4'b1000);
    chk("clr_act_hold", 32'(cnt_act), 0);

    drive(OP_ACT, 1, 1'b0);
    chk("pre_rst_act", 32'(cnt_act), 1);
    rst = 1'b1;
    nop();
    chk("mid_rst_open", 32'(bank_open), 0);
    chk("mid_rst_act", 32'(cnt_act), 0);
    chk_err("mid_rst", 1'b0, 4'd0, 2'd0);
    chk("mid_rst_sticky", 32'(err_sticky), 0);
    rst = 1'b0;
    settle();
    chk("post_rst_open", 32'(bank_open), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
